// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and datapath widths used by
// both the transmitter and the receiver.
package uart_pkg;
  localparam int DATA_W = 16;
  localparam int DIV_W  = 16;
  localparam int BPW_W  = 5;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} uart_state_e;
endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the asynchronous rx line plus a one-cycle
// falling-edge strobe on the synchronised value.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rxs,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs_q;

  // Flops reset to the idle-high line level so reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      rxs_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rxs_q  <= rxs;
    end
  end

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign fall = rxs_q & ~rxs;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of start/data/parity/stop bits, word held
// for the host until rd_en, with parity, framing and overrun reporting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [BPW_W-1:0]  bits_per_word,
  input  logic              parity_en,
  input  logic              parity_evan_odd,
  input  logic              two_stop_bit,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);
  uart_state_e       state, state_n;
  logic              rxs, fall;
  logic [DIV_W-1:0]  cnt, div_l;
  logic [BPW_W-1:0]  bpw_l;
  logic              pen_l, peo_l, two_l;
  logic [3:0]        bit_pos;
  logic [DATA_W-1:0] shift, mask;
  logic              par, perr, ferr, ferr_n;
  logic              tick, complete;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .rxs (rxs),
    .fall(fall)
  );

  assign tick = (state inside {DATA, PARITY, STOP, STOP2}) && (cnt == div_l - DIV_W'(1));
  assign busy = (state != IDLE);

  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_W; i++) mask[i] = (BPW_W'(i) <= bpw_l);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    complete = 1'b0;
    ferr_n   = ferr;
    unique case (state)
      IDLE:   if (fall) state_n = START;
      START:  if (cnt == (div_l >> 1)) state_n = rxs ? IDLE : DATA;
      DATA:   if (tick && ({1'b0, bit_pos} == bpw_l)) state_n = pen_l ? PARITY : STOP;
      PARITY: if (tick) state_n = STOP;
      STOP: if (tick) begin
        ferr_n = ~rxs;
        if (two_l) state_n = STOP2;
        else begin
          state_n  = IDLE;
          complete = 1'b1;
        end
      end
      STOP2: if (tick) begin
        ferr_n   = ferr | ~rxs;
        state_n  = IDLE;
        complete = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      div_l      <= '0;
      bpw_l      <= '0;
      pen_l      <= 1'b0;
      peo_l      <= 1'b0;
      two_l      <= 1'b0;
      bit_pos    <= '0;
      shift      <= '0;
      par        <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (state_n != state || tick) cnt <= '0;
      else if (state != IDLE)       cnt <= cnt + DIV_W'(1);

      // Frame configuration is frozen at the start edge.
      if (state == IDLE && fall) begin
        div_l <= clk_div;
        bpw_l <= bits_per_word;
        pen_l <= parity_en;
        peo_l <= parity_evan_odd;
        two_l <= two_stop_bit;
      end

      if (state == START && state_n == DATA) begin
        bit_pos <= '0;
        par     <= peo_l;
      end
      if (state == DATA && tick) begin
        shift[bit_pos] <= rxs;
        par            <= par ^ rxs;
        bit_pos        <= bit_pos + 4'd1;
      end
      if (state == PARITY && tick) perr <= (rxs != par);
      ferr <= ferr_n;

      // Stale high bits from a longer previous word are masked off here.
      if (complete) begin
        data_out   <= shift & mask;
        parity_err <= pen_l & perr;
        frame_err  <= ferr_n;
        valid      <= 1'b1;
        overrun    <= valid & ~rd_en;
      end else if (rd_en && valid) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: frames are built from the word,
// config and forced bit values; a monitor pops expectations on each new word.
module tb_uart_rx;
  logic        clk, rst, rx, rd_en;
  logic [15:0] clk_div;
  logic [4:0]  bits_per_word;
  logic        parity_en, parity_evan_odd, two_stop_bit;
  logic [15:0] data_out;
  logic        valid, parity_err, frame_err, overrun, busy;

  typedef struct {
    logic [15:0] data;
    logic        perr, ferr, ovr;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  bit   abort_tx = 0;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .clk_div(clk_div), .bits_per_word(bits_per_word),
    .parity_en(parity_en), .parity_evan_odd(parity_evan_odd), .two_stop_bit(two_stop_bit),
    .rd_en(rd_en), .data_out(data_out), .valid(valid), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference frame builder: word LSB first, optional parity, stop bit(s).
  task automatic send_frame(logic [15:0] d, int par_force, logic s1, logic s2,
                            bit push, bit ovr);
    logic        bits[$];
    logic [15:0] m;
    logic        ep, p;
    exp_t        e;
    int          n;
    n  = int'(bits_per_word) + 1;
    m  = 16'((32'h1 << n) - 1);
    ep = parity_evan_odd ^ (^(d & m));
    p  = (par_force < 0) ? ep : par_force[0];
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) bits.push_back(d[i]);
    if (parity_en) bits.push_back(p);
    bits.push_back(s1);
    if (two_stop_bit) bits.push_back(s2);
    e.data = d & m;
    e.perr = parity_en && (p != ep);
    e.ferr = !s1 || (two_stop_bit && !s2);
    e.ovr  = ovr;
    if (push) q.push_back(e);
    foreach (bits[k]) begin
      rx = bits[k];
      for (int c = 0; c < int'(clk_div); c++) begin
        @(negedge clk);
        if (abort_tx) begin
          rx = 1'b1;
          return;
        end
      end
    end
    rx = 1'b1;
  endtask

  task automatic wait_valid(string nm);
    int n = 0;
    while (!valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, valid, 1);
  endtask

  task automatic read_word(string nm);
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk({nm, "_valid_clr"}, valid, 0);
    chk({nm, "_ovr_clr"}, overrun, 0);
  endtask

  task automatic set_cfg(int div, int bpw, bit pen, bit peo, bit two);
    clk_div         = 16'(div);
    bits_per_word   = 5'(bpw);
    parity_en       = pen;
    parity_evan_odd = peo;
    two_stop_bit    = two;
  endtask

  // Monitor: a new word is a rise of valid, or an overwrite while valid holds.
  initial begin
    logic        vprev = 0, oprev = 0, pprev = 0, fprev = 0;
    logic [15:0] dprev = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst && valid && (!vprev || (overrun && !oprev) || data_out != dprev ||
                            parity_err != pprev || frame_err != fprev)) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got %0h expected none", data_out);
        end else begin
          e = q.pop_front();
          chk("data_out", data_out, e.data);
          chk("parity_err", parity_err, e.perr);
          chk("frame_err", frame_err, e.ferr);
          chk("overrun", overrun, e.ovr);
        end
      end
      vprev = valid; oprev = overrun; dprev = data_out;
      pprev = parity_err; fprev = frame_err;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; rx = 1; rd_en = 0;
    set_cfg(16, 7, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    repeat (4) @(negedge clk);

    send_frame(16'h00A5, -1, 1, 1, 1, 0);
    wait_valid("a5_valid");
    read_word("a5");

    set_cfg(16, 7, 1, 0, 0);
    send_frame(16'h0007, -1, 1, 1, 1, 0);
    wait_valid("par_ok_valid");
    read_word("par_ok");
    send_frame(16'h0007, 0, 1, 1, 1, 0);
    wait_valid("par_bad_valid");
    read_word("par_bad");

    set_cfg(16, 15, 0, 0, 1);
    send_frame(16'hBEEF, -1, 1, 0, 1, 0);
    wait_valid("beef_valid");
    read_word("beef");

    set_cfg(16, 7, 0, 0, 0);
    rx = 0;
    repeat (3) @(negedge clk);
    rx = 1;
    repeat (11) @(negedge clk);
    chk("glitch_busy", busy, 0);
    repeat (30) @(negedge clk);
    chk("glitch_valid", valid, 0);

    send_frame(16'h0011, -1, 1, 1, 1, 0);
    send_frame(16'h0022, -1, 1, 1, 1, 1);
    wait_valid("b2b_valid");
    chk("b2b_data", data_out, 16'h0022);
    chk("b2b_ovr", overrun, 1);
    read_word("b2b");

    fork
      send_frame(16'h005A, -1, 1, 1, 0, 0);
      begin
        repeat (16 * 4) @(negedge clk);
        rst = 1;
        abort_tx = 1;
      end
    join
    repeat (2) @(negedge clk);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 0;
    abort_tx = 0;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    send_frame(16'h003C, -1, 1, 1, 1, 0);
    wait_valid("3c_valid");
    read_word("3c");

    for (int t = 0; t < 25; t++) begin
      int pf;
      set_cfg($urandom_range(24, 8), $urandom_range(15, 0), 1'($urandom),
              1'($urandom), 1'($urandom));
      pf = ($urandom_range(7, 0) == 0) ? int'($urandom_range(1, 0)) : -1;
      send_frame(16'($urandom), pf, $urandom_range(7, 0) != 0,
                 $urandom_range(7, 0) != 0, 1, 0);
      wait_valid("rnd_valid");
      read_word("rnd");
      repeat ($urandom_range(5, 0)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. Sits directly downstream of uart_tx and deserialises its tx line into parallel words.
- Uses the same configuration inputs as uart_tx: clk_div, bits_per_word, parity_en, parity_evan_odd and two_stop_bit.
- Holds each received word until the host register logic reads it with rd_en. Reports parity, framing and overrun errors.

Parameters:
SYNC_STAGES, 2, number of flops in the rx input synchroniser (minimum 2)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
rx  input  1  serial line, asynchronous to clk, idle high
clk_div  input  16  bit period in clk cycles (valid range 4..65535)
bits_per_word  input  5  index of last data bit; word length = bits_per_word+1 (0..15)
parity_en  input  1  1 = parity bit follows data
parity_evan_odd  input  1  parity seed: expected parity = parity_evan_odd XOR (XOR of data bits)
two_stop_bit  input  1  1 = two stop bits checked
rd_en  input  1  host read strobe; clears valid and overrun
data_out  output  16  last received word, LSB = first bit received, unused upper bits 0
valid  output  1  level: unread word present in data_out
parity_err  output  1  parity mismatch on word in data_out
frame_err  output  1  a stop bit sampled low on word in data_out
overrun  output  1  sticky: a word completed while valid=1 and no rd_en
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (async, rst=1): all outputs 0; synchroniser flops set to 1; state IDLE; counters 0.
- rx passes through the SYNC_STAGES synchroniser. rxs is the synchronised value; rxs_q is rxs delayed one cycle.
- Bit counter cnt (16 bit) restarts at 0 on each state entry and counts up.
- half = clk_div>>1. A bit tick occurs when cnt == clk_div-1; cnt then returns to 0.
- Configuration is latched on start detection: clk_div, bits_per_word, parity_en, parity_evan_odd, two_stop_bit. Changes mid-frame have no effect on that frame.
- State IDLE: falling edge (rxs_q=1, rxs=0) -> START, cnt=0.
- State START: at cnt==half, sample rxs:
  - 0 -> DATA, cnt=0, bit_pos=0, par=latched parity_evan_odd.
  - 1 -> IDLE (false start, nothing reported).
- State DATA: on each bit tick (mid-bit):
  - shift[bit_pos] <= rxs; par <= par ^ rxs.
  - If bit_pos == bits_per_word: go to PARITY if parity_en, else STOP. Otherwise bit_pos+1.
- State PARITY: on bit tick, perr <= (rxs != par); -> STOP.
- State STOP: on bit tick, ferr <= (rxs==0).
  - If two_stop_bit -> STOP2, else complete.
- State STOP2: on bit tick, ferr <= ferr | (rxs==0); complete.
- Complete, in the same cycle as the final stop sample:
  - Register outputs on the next edge: data_out <= shift with bits above bits_per_word zeroed; parity_err <= perr (0 if parity disabled); frame_err <= ferr.
  - valid <= 1; state -> IDLE.
  - Latency: valid rises 1 cycle after the last stop mid-sample. The receiver then re-arms mid-stop-bit, so back-to-back frames are accepted.
- rd_en with valid=1: valid <= 0, overrun <= 0. rd_en with valid=0 is ignored.
- Completion while valid=1 and rd_en=0: data_out and error flags are overwritten, valid stays 1, overrun <= 1.
- Completion and rd_en in the same cycle: new word is loaded, valid=1, overrun=0.
- A frame error does not block the next frame. A break (rx held low) produces one frame with frame_err=1, then waits in IDLE for a new falling edge.
- rst asserted mid-frame: the frame is aborted immediately with no output update. After release, a falling edge is required before reception restarts.

Decomposition:
- Shared package uart_pkg holds:
  - the state encodings common to uart_tx/uart_rx (IDLE, START, DATA, PARITY, STOP, STOP2);
  - width constants DATA_W=16, DIV_W=16, BPW_W=5.
- One sub-module: uart_rx_sync, containing the SYNC_STAGES synchroniser plus falling-edge detect. Outputs are rxs and fall.

Test Plan:
- clk_div=16, bits_per_word=7, no parity, one stop bit; transmit 0xA5 -> data_out=0x00A5, valid=1, parity_err=0, frame_err=0, no rd_en needed to observe.
- parity_en=1, parity_evan_odd=0, send 0x07 with parity bit 1 -> parity_err=0; same word with parity bit forced 0 -> parity_err=1.
- bits_per_word=15, two_stop_bit=1, send 0xBEEF with second stop bit forced low -> data_out=0xBEEF, frame_err=1.
- 3-cycle low glitch on idle rx (clk_div=16) -> no valid, busy returns to 0 by cycle half+SYNC_STAGES+2.
- Two back-to-back frames 0x11, 0x22, no rd_en -> data_out=0x0022, valid=1, overrun=1; then rd_en -> valid=0, overrun=0.
- rst pulsed mid-DATA of 0x5A, line then idle -> all outputs 0; next full frame 0x3C received correctly.
